pair_select_ctrl: RTL and testbench

- Selection controller for the 6x6 tile board.
- Consumes the one-hot cursor position and a select pulse, and latches the first and second picked tiles.
- Sequences a path/match check via a req/ack handshake, then either issues a clear command for both tiles or shows a timed fail highlight.
- Counts cleared pairs and flags game completion.
- Sits between the cursor block, the match checker and the board store.

---
 rtl/pair_select_ctrl.sv | 137 +++++++++++++
 tb/tb_pair_select_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pair_select_ctrl.sv
// pair_select_ctrl: two-tile selection controller for the 6x6 board.
// Latches a tile pair, runs the match-check handshake, then clears the pair or shows a timed fail.
`default_nettype none

module pair_select_ctrl #(
  parameter int N_TILES     = 36,
  parameter int IDX_W       = 6,
  parameter int PAIRS       = 18,
  parameter int FAIL_CYCLES = 16,
  parameter int CHK_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_TILES-1:0] cur_bus,
  input  logic               sel,
  input  logic [N_TILES-1:0] tile_mask,
  output logic               chk_req,
  output logic [IDX_W-1:0]   chk_a,
  output logic [IDX_W-1:0]   chk_b,
  input  logic               chk_ack,
  input  logic               chk_ok,
  output logic               clr_valid,
  output logic [IDX_W-1:0]   clr_a,
  output logic [IDX_W-1:0]   clr_b,
  output logic [N_TILES-1:0] sel_bus,
  output logic [4:0]         pair_cnt,
  output logic               busy,
  output logic               fail_flag,
  output logic               done
);

  localparam int TMR_MAX = (CHK_TIMEOUT > FAIL_CYCLES) ? CHK_TIMEOUT : FAIL_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [N_TILES-1:0] BIT0 = {{(N_TILES-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ONE   = 3'd1,
    S_CHECK = 3'd2,
    S_CLEAR = 3'd3,
    S_FAIL  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx_a, idx_b, cur_idx;
  logic               cur_valid, accept;
  logic [TMR_W-1:0]   timer;
  logic [4:0]         cnt_inc;

  // Cursor encode; a zero or multi-hot bus is never a valid position.
  always_comb begin
    cur_idx = '0;
    for (int i = 0; i < N_TILES; i++) begin
      if (cur_bus[i]) cur_idx = IDX_W'(i);
    end
    cur_valid = (cur_bus != '0) && ((cur_bus & (cur_bus - BIT0)) == '0);
    accept    = sel && cur_valid && tile_mask[cur_idx];
    cnt_inc   = (pair_cnt == 5'(PAIRS)) ? pair_cnt : pair_cnt + 5'd1;
  end

  always_comb begin
    state_nx  = state;
    chk_req   = 1'b0;
    clr_valid = 1'b0;
    busy      = 1'b0;
    fail_flag = 1'b0;
    done      = 1'b0;
    sel_bus   = '0;
    case (state)
      S_IDLE: begin
        if (accept) state_nx = S_ONE;
      end
      S_ONE: begin
        sel_bus = BIT0 << idx_a;
        if (!tile_mask[idx_a])  state_nx = S_IDLE;
        else if (accept)        state_nx = (cur_idx == idx_a) ? S_IDLE : S_CHECK;
      end
      S_CHECK: begin
        chk_req = 1'b1;
        busy    = 1'b1;
        sel_bus = (BIT0 << idx_a) | (BIT0 << idx_b);
        // An ack on the last timeout cycle still wins.
        if (chk_ack)                                  state_nx = chk_ok ? S_CLEAR : S_FAIL;
        else if (timer == TMR_W'(CHK_TIMEOUT - 1))    state_nx = S_FAIL;
      end
      S_CLEAR: begin
        clr_valid = 1'b1;
        busy      = 1'b1;
        state_nx  = (cnt_inc == 5'(PAIRS)) ? S_DONE : S_IDLE;
      end
      S_FAIL: begin
        fail_flag = 1'b1;
        busy      = 1'b1;
        sel_bus   = (BIT0 << idx_a) | (BIT0 << idx_b);
        if (timer == TMR_W'(FAIL_CYCLES - 1)) state_nx = S_IDLE;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx_a    <= '0;
      idx_b    <= '0;
      timer    <= '0;
      pair_cnt <= '0;
      chk_a    <= '0;
      chk_b    <= '0;
      clr_a    <= '0;
      clr_b    <= '0;
    end else begin
      state <= state_nx;
      // Timer restarts on every state change so CHECK and FAIL each count from zero.
      if (state_nx != state || !(state == S_CHECK || state == S_FAIL)) timer <= '0;
      else                                                              timer <= timer + TMR_W'(1);
      if (state == S_IDLE && state_nx == S_ONE) idx_a <= cur_idx;
      if (state == S_ONE && state_nx == S_CHECK) begin
        idx_b <= cur_idx;
        chk_a <= idx_a;
        chk_b <= cur_idx;
      end
      if (state == S_CHECK && state_nx == S_CLEAR) begin
        clr_a <= idx_a;
        clr_b <= idx_b;
      end
      if (state == S_CLEAR) pair_cnt <= cnt_inc;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pair_select_ctrl.sv
// tb_pair_select_ctrl: directed self-checking bench for pair_select_ctrl.
`default_nettype none

module tb_pair_select_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [35:0] cur_bus;
  logic        sel;
  logic [35:0] tile_mask;
  logic        chk_req;
  logic [5:0]  chk_a, chk_b;
  logic        chk_ack, chk_ok;
  logic        clr_valid;
  logic [5:0]  clr_a, clr_b;
  logic [35:0] sel_bus;
  logic [4:0]  pair_cnt;
  logic        busy, fail_flag, done;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  pair_select_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cur_bus   (cur_bus),
    .sel       (sel),
    .tile_mask (tile_mask),
    .chk_req   (chk_req),
    .chk_a     (chk_a),
    .chk_b     (chk_b),
    .chk_ack   (chk_ack),
    .chk_ok    (chk_ok),
    .clr_valid (clr_valid),
    .clr_a     (clr_a),
    .clr_b     (clr_b),
    .sel_bus   (sel_bus),
    .pair_cnt  (pair_cnt),
    .busy      (busy),
    .fail_flag (fail_flag),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int idx);
    cur_bus = 36'd1 << idx;
    sel     = 1'b1;
    tick();
    sel     = 1'b0;
    cur_bus = '0;
  endtask

  function automatic logic [35:0] bits2(input int a, input int b);
    logic [35:0] one;
    one = 36'd1;
    return (one << a) | (one << b);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst = 1'b1; sel = 1'b0; chk_ack = 1'b0; chk_ok = 1'b0;
    cur_bus = '0; tile_mask = '1;
    tick(); tick();
    check("rst_chk_req",   chk_req,   0);
    check("rst_sel_bus",   sel_bus,   0);
    check("rst_pair_cnt",  pair_cnt,  0);
    check("rst_flags",     {busy, fail_flag, done, clr_valid}, 0);
    check("rst_idx",       {chk_a, chk_b, clr_a, clr_b}, 0);
    rst = 1'b0;
    tick();

    // Match 0/7, ack ok during the fourth request cycle
    press(0);
    check("m_one_sel_bus", sel_bus, 36'h1);
    press(7);
    check("m_req_c0",      chk_req, 1);
    check("m_chk_ab",      {chk_a, chk_b}, {6'd0, 6'd7});
    check("m_sel_bus2",    sel_bus, 36'h81);
    check("m_busy",        busy, 1);
    tick(); check("m_req_c1", chk_req, 1);
    tick(); check("m_req_c2", chk_req, 1);
    tick(); check("m_req_c3", chk_req, 1);
    chk_ack = 1'b1; chk_ok = 1'b1;
    tick();
    chk_ack = 1'b0; chk_ok = 1'b0;
    check("m_req_drop",    chk_req, 0);
    check("m_clr_valid",   clr_valid, 1);
    check("m_clr_ab",      {clr_a, clr_b}, {6'd0, 6'd7});
    check("m_clr_sel_bus", sel_bus, 0);
    tick();
    check("m_pair_cnt",    pair_cnt, 1);
    check("m_clr_pulse",   clr_valid, 0);
    check("m_hold_ab",     {chk_a, chk_b, clr_a, clr_b}, {6'd0, 6'd7, 6'd0, 6'd7});

    // Deselect and ignored selects
    press(5);
    check("d_one",         sel_bus, 36'h20);
    press(5);
    check("d_deselect",    sel_bus, 0);
    check("d_no_req",      chk_req, 0);
    tile_mask[9] = 1'b0;
    press(9);
    check("d_empty_cell",  sel_bus, 0);
    cur_bus = '0; sel = 1'b1; tick(); sel = 1'b0;
    check("d_zero_bus",    sel_bus, 0);
    cur_bus = 36'h3; sel = 1'b1; tick(); sel = 1'b0; cur_bus = '0;
    check("d_multi_hot",   sel_bus, 0);
    press(4);
    press(9);
    check("d_one_empty",   {chk_req, sel_bus}, {1'b0, 36'h10});
    tile_mask[4] = 1'b0;
    tick();
    check("d_ext_clear",   sel_bus, 0);
    tile_mask = '1;

    // Mismatch 2/3
    press(2); press(3);
    chk_ack = 1'b1; chk_ok = 1'b0;
    tick();
    chk_ack = 1'b0;
    check("f_flag_c0",     fail_flag, 1);
    check("f_sel_bus_c0",  sel_bus, 36'h0000000C);
    check("f_no_clr",      clr_valid, 0);
    cur_bus = 36'd1 << 6; sel = 1'b1; tick(); sel = 1'b0; cur_bus = '0;
    for (int k = 2; k < 16; k++) begin
      tick();
      check("f_hold", {fail_flag, sel_bus}, {1'b1, 36'h0000000C});
    end
    tick();
    check("f_exit_flag",   fail_flag, 0);
    check("f_exit_bus",    sel_bus, 0);
    check("f_pair_cnt",    pair_cnt, 1);

    // Timeout 10/20
    press(10); press(20);
    check("t_req_c0",      chk_req, 1);
    for (int k = 1; k < 64; k++) begin
      tick();
      check("t_req_hold", chk_req, 1);
    end
    tick();
    check("t_req_drop",    chk_req, 0);
    check("t_fail",        {fail_flag, clr_valid}, 2'b10);
    check("t_sel_bus",     sel_bus, bits2(10, 20));
    for (int k = 1; k < 16; k++) tick();
    check("t_fail_last",   fail_flag, 1);
    tick();
    check("t_idle",        {fail_flag, busy, pair_cnt}, 7'd1);

    // Ack on the timeout cycle wins
    press(11); press(12);
    for (int k = 1; k < 64; k++) tick();
    chk_ack = 1'b1; chk_ok = 1'b1;
    tick();
    chk_ack = 1'b0; chk_ok = 1'b0;
    check("c_clear",       {clr_valid, fail_flag}, 2'b10);
    check("c_clr_ab",      {clr_a, clr_b}, {6'd11, 6'd12});
    tick();
    check("c_pair_cnt",    pair_cnt, 2);

    // Completion: 16 more pairs
    for (int p = 0; p < 16; p++) begin
      press(p); press(p + 18);
      chk_ack = 1'b1; chk_ok = 1'b1;
      tick();
      chk_ack = 1'b0; chk_ok = 1'b0;
      tick();
    end
    check("g_pair_cnt",    pair_cnt, 18);
    check("g_done",        {done, busy}, 2'b10);
    press(1); press(2);
    check("g_no_req",      {chk_req, sel_bus}, 37'd0);
    check("g_still_done",  {done, pair_cnt}, {1'b1, 5'd18});
    rst = 1'b1; tick(); rst = 1'b0;
    check("g_rst",         {done, pair_cnt}, 6'd0);

    // Reset mid-check, then a stray ack
    press(0); press(1);
    tick();
    check("r_req_before",  chk_req, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("r_req_drop",    {chk_req, sel_bus, busy}, 38'd0);
    chk_ack = 1'b1; chk_ok = 1'b1;
    tick();
    chk_ack = 1'b0; chk_ok = 1'b0;
    check("r_stray_ack",   clr_valid, 0);
    tick();
    check("r_stray_after", {clr_valid, pair_cnt}, 6'd0);
    press(5);
    chk_ack = 1'b1; chk_ok = 1'b1;
    tick();
    chk_ack = 1'b0; chk_ok = 1'b0;
    check("r_ack_in_one",  {clr_valid, chk_req, sel_bus}, {2'b00, 36'h20});

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

`default_nettype wire
